// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared widths, funct3 codes, FSM encoding and sign helpers for the RV32M unit
package muldiv_pkg;

    localparam int XLEN      = 32;
    localparam int MUL_STEPS = 32;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPECIAL,
        ST_MUL_RUN,
        ST_DIV_ACK,
        ST_DIV_RUN,
        ST_FIXUP,
        ST_DONE,
        ST_DRAIN
    } state_e;

    function automatic logic rs1_is_signed(input logic [2:0] op);
        return (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] op);
        return (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    endfunction

    function automatic logic [XLEN-1:0] apply_sign(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - unsigned WIDTH x WIDTH iterative multiplier, one partial product per cycle
module shift_add_multiplier #(
    parameter int WIDTH = 32,
    parameter int STEPS = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
);
    localparam int CW = $clog2(STEPS + 1);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic [WIDTH:0]     sum;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    end

    // done is raised during the final iteration; product is complete the cycle after.
    assign done    = run_q && (cnt_q == CW'(STEPS - 1));
    assign product = prod_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else if (start) begin
            run_q   <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
        end else if (run_q) begin
            prod_q <= {sum, prod_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + CW'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/muldiv_control.sv
// rtl/muldiv_control.sv - RV32M issue/completion: special cases, magnitudes, mul/div sequencing, sign fix-up
module muldiv_control
    import muldiv_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            div_start,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    input  logic            div_busy,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);
    state_e            state_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              neg1_q, neg2_q;
    logic [XLEN-1:0]   mag1_q, mag2_q;
    logic              out_valid_q, div_start_q;
    logic [XLEN-1:0]   out_data_q;
    logic [4:0]        out_rd_q;

    logic              accept, neg1_in, neg2_in, special_in, mul_start, mul_done;
    logic [XLEN-1:0]   mag1_in, mag2_in, special_res, fix_res, quo_fix, rem_fix;
    logic [2*XLEN-1:0] mul_product, prod_fix;

    always_comb begin
        accept     = (state_q == ST_IDLE) && in_valid && !kill;
        neg1_in    = rs1_is_signed(in_op) && in_rs1[XLEN-1];
        neg2_in    = rs2_is_signed(in_op) && in_rs2[XLEN-1];
        mag1_in    = apply_sign(in_rs1, neg1_in);
        mag2_in    = apply_sign(in_rs2, neg2_in);
        special_in = in_op[2] && ((in_rs2 == '0) ||
                     (((in_op == F3_DIV) || (in_op == F3_REM)) && (in_rs1 == INT_MIN) && (in_rs2 == '1)));
        mul_start  = accept && !in_op[2];
    end

    shift_add_multiplier #(
        .WIDTH (XLEN),
        .STEPS (MUL_STEPS)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (mag1_in),
        .b       (mag2_in),
        .product (mul_product),
        .done    (mul_done)
    );

    // Sign flags are already zero for unsigned ops, so fix-up needs no op decode here.
    always_comb begin
        prod_fix = (neg1_q ^ neg2_q) ? (~mul_product + 1'b1) : mul_product;
        quo_fix  = apply_sign(div_quotient, neg1_q ^ neg2_q);
        rem_fix  = apply_sign(div_remainder, neg1_q);
        case (op_q)
            F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
        // op_q[1] separates REM* from DIV*; rs1 is rebuilt from its stored magnitude.
        if (mag2_q == '0) begin
            special_res = op_q[1] ? apply_sign(mag1_q, neg1_q) : '1;
        end else begin
            special_res = op_q[1] ? '0 : INT_MIN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= div_busy ? ST_DRAIN : ST_IDLE;
            out_valid_q <= 1'b0;
            div_start_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
            mag1_q      <= '0;
            mag2_q      <= '0;
        end else begin
            div_start_q <= 1'b0;
            if (accept) begin
                op_q   <= in_op;
                rd_q   <= in_rd;
                neg1_q <= neg1_in;
                neg2_q <= neg2_in;
                mag1_q <= mag1_in;
                mag2_q <= mag2_in;
            end
            if (kill) begin
                state_q     <= div_busy ? ST_DRAIN : ST_IDLE;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            if (!in_op[2]) begin
                                state_q <= ST_MUL_RUN;
                            end else if (special_in) begin
                                state_q <= ST_SPECIAL;
                            end else begin
                                state_q     <= ST_DIV_ACK;
                                div_start_q <= 1'b1;
                            end
                        end
                    end
                    ST_SPECIAL: begin
                        out_data_q  <= special_res;
                        out_rd_q    <= rd_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                    ST_MUL_RUN: if (mul_done) state_q <= ST_FIXUP;
                    ST_DIV_ACK: if (div_busy) state_q <= ST_DIV_RUN;
                    ST_DIV_RUN: if (!div_busy) state_q <= ST_FIXUP;
                    ST_FIXUP: begin
                        out_data_q  <= fix_res;
                        out_rd_q    <= rd_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                    ST_DRAIN: if (!div_busy) state_q <= ST_IDLE;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign div_start = div_start_q;
    assign div_a     = mag1_q;
    assign div_b     = mag2_q;

endmodule

// File: tb/tb_muldiv_control.sv
// tb/tb_muldiv_control.sv - self-checking bench for muldiv_control with a behavioural divider core
`timescale 1ns/1ps
module tb_muldiv_control;

    localparam int DIV_LAT = 33;
    localparam int LAT_SPECIAL = 2;
    localparam int LAT_MUL = 34;
    localparam int LAT_DIV = DIV_LAT + 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        kill = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        div_start;
    logic [31:0] div_a, div_b;
    logic        div_busy = 1'b0;
    logic [31:0] div_quotient = '0;
    logic [31:0] div_remainder = '0;

    logic [31:0] dm_a = '0, dm_b = '0;
    int          dm_cnt = 0;
    int          start_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    muldiv_control dut (
        .clock         (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_rs1        (in_rs1),
        .in_rs2        (in_rs2),
        .in_rd         (in_rd),
        .kill          (kill),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .div_start     (div_start),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_busy      (div_busy),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder)
    );

    // Divider core: unresettable, updates on the falling edge, busy for DIV_LAT cycles.
    always @(negedge clk) begin
        if (div_busy) begin
            if (dm_cnt == 1) begin
                div_busy      <= 1'b0;
                div_quotient  <= (dm_b == 0) ? 32'hFFFF_FFFF : dm_a / dm_b;
                div_remainder <= (dm_b == 0) ? dm_a : dm_a % dm_b;
            end
            dm_cnt <= dm_cnt - 1;
        end else if (div_start) begin
            div_busy <= 1'b1;
            dm_cnt   <= DIV_LAT;
            dm_a     <= div_a;
            dm_b     <= div_b;
        end
        if (div_start) start_cnt <= start_cnt + 1;
    end

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return LAT_MUL;
        if (b == 0) return LAT_SPECIAL;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return LAT_SPECIAL;
        return LAT_DIV;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            tick;
            guard++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        tick;
        in_valid = 1'b0;
    endtask

    // After the accept edge N: a value visible after edge N+k is what writeback samples at N+k+1.
    task automatic wait_result(output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                lat  = k + 1;
                break;
            end
            tick;
        end
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_drop"}, 64'(out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat, input int exp_starts);
        int s0, lat;
        bit seen;
        s0 = start_cnt;
        issue(tag, op, a, b, rd);
        wait_result(seen, lat);
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        check({tag, "_rd"}, 64'(out_rd), 64'(rd));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        retire(tag);
        check({tag, "_starts"}, 64'(start_cnt - s0), 64'(exp_starts));
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          starts;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, hold_data;
        logic [4:0]  hold_rd;
        int          lat, guard, bad_ready, bad_valid;
        bit          seen;

        vecs[0]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_DIV,     1};
        vecs[1]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_DIV,     1};
        vecs[2]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, LAT_DIV,     1};
        vecs[3]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_SPECIAL, 0};
        vecs[4]  = '{3'd7, 32'd5,         32'd0,         32'd5,         LAT_SPECIAL, 0};
        vecs[5]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPECIAL, 0};
        vecs[6]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_SPECIAL, 0};
        vecs[7]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         LAT_MUL,     0};
        vecs[8]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL,     0};
        vecs[9]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_MUL,     0};
        vecs[10] = '{3'd0, 32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFF4, LAT_MUL,     0};
        vecs[11] = '{3'd5, 32'd0,         32'd3,         32'd0,         LAT_DIV,     1};
        vecs[12] = '{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_DIV,     1};
        vecs[13] = '{3'd7, 32'hFFFF_FFFF, 32'd16,        32'd15,        LAT_DIV,     1};
        vecs[14] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_SPECIAL, 0};
        vecs[15] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_DIV,     1};

        reset = 1'b1;
        tick;
        tick;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_rd", 64'(out_rd), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        tick;

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                   vecs[i].exp, vecs[i].lat, vecs[i].starts);
        end

        for (int r = 0; r < 24; r++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op($sformatf("rnd%0d_op%0d", r, op), op, a, b, 5'($urandom_range(0, 31)),
                   ref_model(op, a, b), ref_latency(op, a, b),
                   (op >= 3'd4 && ref_latency(op, a, b) == LAT_DIV) ? 1 : 0);
        end

        // Writeback stalls: result and tag must hold, no new op accepted.
        issue("hold", 3'd5, 32'd100, 32'd7, 5'd9);
        wait_result(seen, lat);
        check("hold_seen", 64'(seen), 64'd1);
        hold_data = out_data;
        hold_rd   = out_rd;
        check("hold_data", 64'(hold_data), 64'd14);
        for (int c = 0; c < 5; c++) begin
            tick;
            check($sformatf("hold%0d_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d_data", c), 64'(out_data), 64'(hold_data));
            check($sformatf("hold%0d_rd", c), 64'(out_rd), 64'(hold_rd));
            check($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
        end
        retire("hold");

        // kill together with out_ready in DONE: the result is dropped.
        issue("kill_done", 3'd0, 32'd6, 32'd7, 5'd4);
        wait_result(seen, lat);
        check("kill_done_seen", 64'(seen), 64'd1);
        kill      = 1'b1;
        out_ready = 1'b1;
        tick;
        kill      = 1'b0;
        out_ready = 1'b0;
        check("kill_done_valid", 64'(out_valid), 64'd0);
        check("kill_done_in_ready", 64'(in_ready), 64'd1);

        // kill while the divider runs: drain before accepting again.
        issue("kill_div", 3'd4, 32'd1000, 32'hFFFF_FFF6, 5'd3);
        for (int c = 0; c < 5; c++) tick;
        check("kill_div_busy", 64'(div_busy), 64'd1);
        kill = 1'b1;
        tick;
        kill = 1'b0;
        bad_ready = 0;
        bad_valid = 0;
        guard     = 0;
        while (div_busy && guard < 100) begin
            if (in_ready) bad_ready++;
            if (out_valid) bad_valid++;
            tick;
            guard++;
        end
        check("kill_div_drain_bound", 64'(guard < 100), 64'd1);
        check("kill_div_ready_while_busy", 64'(bad_ready), 64'd0);
        check("kill_div_valid_while_busy", 64'(bad_valid), 64'd0);
        check("kill_div_ready_after", 64'(in_ready), 64'd1);
        check("kill_div_valid_after", 64'(out_valid), 64'd0);
        run_op("after_kill", 3'd4, 32'd1000, 32'hFFFF_FFF6, 5'd5, 32'hFFFF_FF9C, LAT_DIV, 1);

        // Reset in the middle of a multiply.
        issue("rst_mul", 3'd0, 32'd12345, 32'd678, 5'd7);
        for (int c = 0; c < 10; c++) tick;
        reset = 1'b1;
        tick;
        check("rstmul_out_valid", 64'(out_valid), 64'd0);
        check("rstmul_div_start", 64'(div_start), 64'd0);
        check("rstmul_out_data", 64'(out_data), 64'd0);
        check("rstmul_out_rd", 64'(out_rd), 64'd0);
        check("rstmul_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        tick;
        run_op("post_rst_div", 3'd4, 32'd0, 32'd3, 5'd11, 32'd0, LAT_DIV, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
